// File: rtl/adci_pkg.sv
// -----------------------------------------------------------------------------
// adci_pkg
// Shared constants and types for the serial ADC interface.
//   - Frame timing defaults (SCK divider, frame length, command word,
//     result bit position, inter-frame gap, power-up settle time).
//   - Sequencer state encoding.
//   - Small helper for counter widths.
// -----------------------------------------------------------------------------
package adci_pkg;

  // sys_clk cycles per SCK period (even, >= 4)
  localparam int CLK_DIV        = 6;
  // SCK cycles per CSN-low frame
  localparam int FRAME_BITS     = 16;
  // Command shifted out on SDO, MSB first
  localparam logic [15:0] CMD_WORD = 16'hD000;
  // SCK rise index that samples the result MSB
  localparam int DATA_START     = 6;
  // sys_clk cycles CSN stays high between frames
  localparam int CS_IDLE_CYCLES = 12;
  // sys_clk cycles from enable to the first frame
  localparam int STARTUP_CYCLES = 4800;

  localparam int HALF_CYCLES    = CLK_DIV / 2;

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The wait counter serves both STARTUP and GAP, so size it for the longer one
  localparam int WAIT_MAX = (STARTUP_CYCLES > CS_IDLE_CYCLES) ? STARTUP_CYCLES : CS_IDLE_CYCLES;
  localparam int WAIT_W   = cnt_width(WAIT_MAX);
  localparam int BIT_W    = cnt_width(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    FRAME   = 2'd2,
    GAP     = 2'd3
  } adci_state_e;

endpackage

// File: rtl/adci_serial_if_if.sv
// -----------------------------------------------------------------------------
// adci_serial_if_if
// Bundles the ADC serial pins and the result hand-off to the sample manager.
//   SDI       : serial data from ADC
//   SDO       : serial command to ADC
//   SCK       : serial clock to ADC, idle low
//   CSN       : ADC chip select, active low
//   DATA_READ : last captured 8-bit sample
//   RX_DONE   : one-cycle strobe, DATA_READ just updated
// master = the interface block, slave = ADC plus downstream consumer.
// -----------------------------------------------------------------------------
interface adci_serial_if_if;
  logic       SDI;
  logic       SDO;
  logic       SCK;
  logic       CSN;
  logic [7:0] DATA_READ;
  logic       RX_DONE;

  modport master (
    input  SDI,
    output SDO,
    output SCK,
    output CSN,
    output DATA_READ,
    output RX_DONE
  );

  modport slave (
    output SDI,
    input  SDO,
    input  SCK,
    input  CSN,
    input  DATA_READ,
    input  RX_DONE
  );
endinterface

// File: rtl/adci_sck_gen.sv
// -----------------------------------------------------------------------------
// adci_sck_gen
// Produces the registered SCK from sys_clk with a half-period counter.
//   sys_clk : system clock
//   rst_n   : async active-low reset
//   i_run   : SCK runs while high; when low SCK and counter are forced to 0
//   o_sck   : registered serial clock
//   o_rise  : high in the cycle whose closing edge raises SCK
//   o_fall  : high in the cycle whose closing edge lowers SCK
// The ticks are decoded from the registers so logic clocked on the same
// sys_clk edge as the SCK transition can act on them.
// -----------------------------------------------------------------------------
module adci_sck_gen #(
  parameter int HALF_CYCLES = 3
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

  logic [HW-1:0] r_half_cnt;
  logic          r_sck;
  logic          w_wrap;

  assign w_wrap = (r_half_cnt == HW'(HALF_CYCLES - 1));

  // Half-period counter and SCK toggle; idle low whenever not running
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half_cnt <= '0;
      r_sck      <= 1'b0;
    end else if (!i_run) begin
      r_half_cnt <= '0;
      r_sck      <= 1'b0;
    end else if (w_wrap) begin
      r_half_cnt <= '0;
      r_sck      <= ~r_sck;
    end else begin
      r_half_cnt <= r_half_cnt + HW'(1);
    end
  end

  assign o_sck  = r_sck;
  assign o_rise = i_run & w_wrap & ~r_sck;
  assign o_fall = i_run & w_wrap &  r_sck;

endmodule

// File: rtl/adci_serial_if.sv
// -----------------------------------------------------------------------------
// adci_serial_if
// SPI mode-0 master for an external 8-bit serial ADC.
//   sys_clk : system clock, sole clock
//   rst_n   : async active-low reset
//   en      : run enable; low returns to IDLE on the next edge
//   bus     : adci_serial_if_if.master (SDI in; SDO, SCK, CSN, DATA_READ,
//             RX_DONE out, all registered)
// After enable, waits the ADC power-up time, then repeats CSN-low frames of
// FRAME_BITS SCK cycles separated by a CS_IDLE_CYCLES gap. Each completed
// frame loads DATA_READ and pulses RX_DONE on the edge CSN rises.
// -----------------------------------------------------------------------------
module adci_serial_if
  import adci_pkg::*;
(
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  adci_serial_if_if.master bus
);

  adci_state_e r_state;
  adci_state_e w_state_nxt;

  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic [7:0]            r_rx_shift;
  logic [7:0]            r_data;
  logic                  r_csn;
  logic                  r_rx_done;

  logic w_run;
  logic w_sck;
  logic w_rise;
  logic w_fall;
  logic w_last_fall;
  logic w_in_window;
  logic w_csn_nxt;
  logic w_rx_done_nxt;

  // SCK only runs inside a frame; dropping en stops it on the same edge
  assign w_run = (r_state == FRAME) & en;

  adci_sck_gen #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_sck_gen (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .i_run  (w_run),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // r_bit_cnt counts falls, so during rise k it still holds k
  assign w_last_fall = w_fall & (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_in_window = (r_bit_cnt >= BIT_W'(DATA_START)) &
                       (r_bit_cnt <  BIT_W'(DATA_START + 8));

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = STARTUP;
        else    w_state_nxt = IDLE;
      end
      STARTUP: begin
        if (!en)                                            w_state_nxt = IDLE;
        else if (r_wait_cnt == WAIT_W'(STARTUP_CYCLES - 1)) w_state_nxt = FRAME;
        else                                                w_state_nxt = STARTUP;
      end
      FRAME: begin
        if (!en)              w_state_nxt = IDLE;
        else if (w_last_fall) w_state_nxt = GAP;
        else                  w_state_nxt = FRAME;
      end
      GAP: begin
        if (!en)                                            w_state_nxt = IDLE;
        else if (r_wait_cnt == WAIT_W'(CS_IDLE_CYCLES - 1)) w_state_nxt = FRAME;
        else                                                w_state_nxt = GAP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs, computed for the coming edge so the pins are registered
  always_comb begin
    w_csn_nxt     = 1'b1;
    w_rx_done_nxt = 1'b0;
    if (w_state_nxt == FRAME) begin
      w_csn_nxt = 1'b0;
    end else begin
      w_csn_nxt = 1'b1;
    end
    if (w_last_fall) begin
      w_rx_done_nxt = 1'b1;
    end else begin
      w_rx_done_nxt = 1'b0;
    end
  end

  // STARTUP / GAP wait counter, restarted on every state change
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait_cnt <= '0;
    end else if ((r_state == STARTUP) || (r_state == GAP)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Bit counter: number of SCK falls seen in the current frame
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (w_state_nxt != FRAME) begin
      r_bit_cnt <= '0;
    end else if (w_fall) begin
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Command shifter: MSB is on SDO from CSN fall, advances on each SCK fall
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
    end else if (w_state_nxt != FRAME) begin
      r_tx_shift <= '0;
    end else if (r_state != FRAME) begin
      r_tx_shift <= CMD_WORD;
    end else if (w_fall) begin
      r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
    end else begin
      r_tx_shift <= r_tx_shift;
    end
  end

  // Result capture: only the 8 rises holding the sample are kept, MSB first
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= 8'h00;
    end else if (w_rise && w_in_window) begin
      r_rx_shift <= {r_rx_shift[6:0], bus.SDI};
    end else begin
      r_rx_shift <= r_rx_shift;
    end
  end

  // Output registers: CSN, RX_DONE strobe and held sample
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csn     <= 1'b1;
      r_rx_done <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_csn     <= w_csn_nxt;
      r_rx_done <= w_rx_done_nxt;
      if (w_rx_done_nxt) begin
        r_data <= r_rx_shift;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign bus.SDO       = r_tx_shift[FRAME_BITS-1];
  assign bus.SCK       = w_sck;
  assign bus.CSN       = r_csn;
  assign bus.DATA_READ = r_data;
  assign bus.RX_DONE   = r_rx_done;

endmodule

// File: tb/tb_adci_serial_if.sv
// -----------------------------------------------------------------------------
// tb_adci_serial_if
// Drives adci_serial_if with an ADC pin model and compares every cycle with a
// timeline model: given the number of cycles since enable was first seen,
// CSN/SCK/SDO/RX_DONE/DATA_READ follow from startup, frame and gap lengths.
// -----------------------------------------------------------------------------
module tb_adci_serial_if;

  localparam int T_STARTUP = 4800;
  localparam int T_DIV     = 6;
  localparam int T_BITS    = 16;
  localparam int T_LOW     = T_BITS * T_DIV;   // 96
  localparam int T_PERIOD  = T_LOW + 12;       // 108
  localparam logic [15:0] T_CMD = 16'hD000;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic en;

  adci_serial_if_if bus ();

  adci_serial_if dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .en     (en),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // timeline model
  bit         running;
  int         c;
  int         run_no;
  logic [15:0] words [8];
  logic       exp_csn, exp_sck, exp_sdo, exp_rx;
  logic [7:0] exp_data;
  logic [7:0] fixed_samp [4];

  // ADC pin model
  int          adc_frame;
  int          adc_bit;
  logic [15:0] adc_cmd;
  logic        prev_csn, prev_sck;
  int          last_rx;
  bit          last_rx_ok;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame word bit (15-k) is the SDI value for SCK rise k; sample sits on rises 6..13
  task automatic new_run_words(input bit fixed);
    logic [7:0] samp;
    logic [7:0] fill;
    for (int i = 0; i < 8; i++) begin
      samp = 8'($urandom);
      fill = 8'($urandom);
      if (fixed && i < 4) words[i] = {6'h3F, fixed_samp[i], 2'b11};
      else                words[i] = {fill[5:0], samp, fill[7:6]};
    end
  endtask

  task automatic model_edge();
    int q, f, p;
    logic [15:0] w;
    logic [15:0] cmd;
    cyc++;
    if (!rst_n) begin
      running  = 1'b0;
      exp_data = 8'h00;
    end else if (en) begin
      if (running) begin
        c++;
      end else begin
        running = 1'b1;
        c = 0;
        run_no++;
        new_run_words(run_no == 1);
        adc_frame  = -1;
        adc_bit    = 0;
        last_rx_ok = 1'b0;
      end
    end else begin
      running = 1'b0;
    end
    exp_csn = 1'b1; exp_sck = 1'b0; exp_sdo = 1'b0; exp_rx = 1'b0;
    if (running && c >= T_STARTUP) begin
      q = c - T_STARTUP;
      f = q / T_PERIOD;
      p = q % T_PERIOD;
      if (p < T_LOW) begin
        cmd     = T_CMD;
        exp_csn = 1'b0;
        exp_sck = ((p % T_DIV) >= T_DIV / 2);
        exp_sdo = cmd[T_BITS - 1 - p / T_DIV];
      end else if (p == T_LOW) begin
        exp_rx = 1'b1;
        if (f < 8) begin
          w = words[f];
          exp_data = w[9:2];
        end
      end
    end
  endtask

  task automatic compare_and_drive();
    logic [15:0] w;
    check_eq("csn",       32'(bus.CSN),       32'(exp_csn));
    check_eq("sck",       32'(bus.SCK),       32'(exp_sck));
    check_eq("sdo",       32'(bus.SDO),       32'(exp_sdo));
    check_eq("rx_done",   32'(bus.RX_DONE),   32'(exp_rx));
    check_eq("data_read", 32'(bus.DATA_READ), 32'(exp_data));
    if (prev_csn && !bus.CSN) begin
      adc_frame++;
      adc_bit = 0;
      adc_cmd = 16'h0000;
    end
    if (!bus.CSN && !prev_sck && bus.SCK) begin
      adc_cmd = {adc_cmd[14:0], bus.SDO};
      adc_bit++;
    end
    if (!prev_csn && bus.CSN && adc_bit == T_BITS) begin
      check_eq("sdo_stream", 32'(adc_cmd), 32'(T_CMD));
    end
    if (bus.RX_DONE) begin
      if (last_rx_ok) check_eq("rx_period", 32'(cyc - last_rx), 32'(T_PERIOD));
      last_rx    = cyc;
      last_rx_ok = 1'b1;
    end
    if (!bus.CSN && adc_frame >= 0 && adc_frame < 8 && adc_bit < T_BITS) begin
      w = words[adc_frame];
      bus.SDI = w[15 - adc_bit];
    end else begin
      bus.SDI = 1'b1;
    end
    prev_csn = bus.CSN;
    prev_sck = bus.SCK;
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_and_drive();
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (!(running && c >= target) && guard < 6000) begin
      step();
      guard++;
    end
    check_eq("reach_target", 32'(running && c >= target), 32'd1);
  endtask

  initial begin
    fixed_samp[0] = 8'hA5;
    fixed_samp[1] = 8'h00;
    fixed_samp[2] = 8'hFF;
    fixed_samp[3] = 8'h3C;
    running = 1'b0; c = 0; run_no = 0; exp_data = 8'h00;
    exp_csn = 1'b1; exp_sck = 1'b0; exp_sdo = 1'b0; exp_rx = 1'b0;
    adc_frame = -1; adc_bit = 0; adc_cmd = 16'h0000;
    prev_csn = 1'b1; prev_sck = 1'b0; last_rx = 0; last_rx_ok = 1'b0;
    rst_n   = 1'b0;
    en      = 1'b1;
    bus.SDI = 1'b1;

    // held in reset with en high
    repeat (10) step();
    rst_n = 1'b1;

    // startup, then frames A5, 00, FF, 3C; abort at rise 8 of the fifth frame
    run_until(T_STARTUP + 4 * T_PERIOD + 3 + 8 * T_DIV);
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;

    // full startup again, one frame, then reset during rise 10 of the next
    run_until(T_STARTUP + T_PERIOD + 3 + 10 * T_DIV);
    rst_n = 1'b0;
    #1;
    check_eq("rst_csn",  32'(bus.CSN),       32'd1);
    check_eq("rst_sck",  32'(bus.SCK),       32'd0);
    check_eq("rst_sdo",  32'(bus.SDO),       32'd0);
    check_eq("rst_rx",   32'(bus.RX_DONE),   32'd0);
    check_eq("rst_data", 32'(bus.DATA_READ), 32'd0);
    exp_data = 8'h00;
    running  = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;

    // recovery: startup and one complete frame
    run_until(T_STARTUP + T_LOW + 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
